// File: rtl/delay_tap_reader_if.sv
// delay_tap_reader_if: sample strobe, tap offsets and tap output stream of the delay tap reader
interface delay_tap_reader_if #(
  parameter int WIDTH = 12,
  parameter int AW = 10,
  parameter int NTAPS = 4,
  parameter int TW = 2
);
  logic enable;
  logic [WIDTH-1:0] in;
  logic [NTAPS*AW-1:0] tap_offset;
  logic [WIDTH-1:0] out;
  logic out_valid;
  logic out_ready;
  logic [TW-1:0] out_tap;
  logic out_last;
  logic busy;
  logic overrun;
  modport master(
    output enable, in, tap_offset, out_ready,
    input out, out_valid, out_tap, out_last, busy, overrun
  );
  modport slave(
    input enable, in, tap_offset, out_ready,
    output out, out_valid, out_tap, out_last, busy, overrun
  );
endinterface

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: circular sample buffer streaming NTAPS delayed samples per strobe over valid/ready
module delay_tap_reader #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1024,
  parameter int NTAPS = 4
) (
  input logic clk,
  input logic rst,
  delay_tap_reader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = NTAPS > 1 ? $clog2(NTAPS) : 1;
  typedef enum logic [1:0] {IDLE, READ, PRESENT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, base_q, base_d, raddr;
  logic [AW:0] fill_q, fill_d;
  logic [AW-1:0] off_q [NTAPS];
  logic [AW-1:0] off_d [NTAPS];
  logic [TW-1:0] k_q, k_d;
  logic zero_q, zero_d, overrun_q, overrun_d, last;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_comb begin
    wptr_d = bus.enable ? wptr_q + 1'b1 : wptr_q;
    fill_d = (bus.enable && fill_q != (AW+1)'(DEPTH)) ? fill_q + 1'b1 : fill_q;
    overrun_d = bus.enable && state_q != IDLE;
    raddr = base_q - off_q[k_q];
    last = k_q == TW'(NTAPS - 1);
    state_d = state_q;
    base_d = base_q;
    off_d = off_q;
    k_d = k_q;
    zero_d = zero_q;
    unique case (state_q)
      IDLE: if (bus.enable) begin
        base_d = wptr_q;
        for (int i = 0; i < NTAPS; i++) off_d[i] = bus.tap_offset[i*AW +: AW];
        k_d = '0;
        state_d = READ;
      end
      // a tap reaching past the written history reads as silence
      READ: begin
        zero_d = {1'b0, off_q[k_q]} >= fill_q;
        state_d = PRESENT;
      end
      PRESENT: if (bus.out_ready) begin
        state_d = last ? IDLE : READ;
        k_d = last ? k_q : k_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      fill_q <= '0;
      k_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      k_q <= k_d;
      overrun_q <= overrun_d;
      base_q <= base_d;
      off_q <= off_d;
      zero_q <= zero_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && bus.enable) mem[wptr_q] <= bus.in;
    if (state_q == READ) rdata_q <= mem[raddr];
  end
  assign bus.out = (state_q == PRESENT && !zero_q) ? rdata_q : '0;
  assign bus.out_valid = state_q == PRESENT;
  assign bus.out_tap = state_q == PRESENT ? k_q : '0;
  assign bus.out_last = state_q == PRESENT && last;
  assign bus.busy = state_q != IDLE;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_delay_tap_reader.sv
// tb_delay_tap_reader: scoreboard bench for delay_tap_reader with DEPTH=16, NTAPS=4, offsets {0,1,3,15}
module tb_delay_tap_reader;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int offs [4] = '{0, 1, 3, 15};
  typedef struct {logic [1:0] tap; logic last; logic [11:0] data;} exp_t;
  exp_t sb [$];
  exp_t e;
  logic [11:0] hist [$];
  delay_tap_reader_if #(.WIDTH(12), .AW(4), .NTAPS(4), .TW(2)) bus ();
  delay_tap_reader #(.WIDTH(12), .DEPTH(16), .NTAPS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask
  // inputs settle between negedge and the next posedge, so this sees exactly the accepted beats
  always @(negedge clk) if (!rst && bus.out_valid && bus.out_ready) begin
    if (sb.size() == 0) check("underflow", 1, 0);
    else begin
      e = sb.pop_front();
      check("data", bus.out, e.data);
      check("tap", bus.out_tap, e.tap);
      check("last", bus.out_last, e.last);
    end
  end
  task automatic clear_model();
    sb.delete();
    hist.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
  endtask
  task automatic strobe(input logic [11:0] v);
    bus.enable = 1'b1;
    bus.in = v;
    hist.push_back(v);
    if (hist.size() > 16) void'(hist.pop_front());
    if (!bus.busy)
      for (int k = 0; k < 4; k++)
        sb.push_back('{tap: 2'(k), last: k == 3,
                       data: offs[k] < hist.size() ? hist[hist.size() - 1 - offs[k]] : 12'h0});
    @(posedge clk);
    #1 bus.enable = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check("idle", 32'(bus.busy || sb.size() != 0), 0);
  endtask
  task automatic wait_tap(input logic [1:0] k);
    int n = 0;
    while (!(bus.out_valid && bus.out_tap == k) && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("wait_tap", 32'(bus.out_valid && bus.out_tap == k), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.in = '0;
    bus.out_ready = 1'b1;
    bus.tap_offset = {4'd15, 4'd3, 4'd1, 4'd0};
    do_reset();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_out", bus.out, 0);
    check("rst_tap", bus.out_tap, 0);
    check("rst_last", bus.out_last, 0);
    strobe(12'h001);
    check("lat_n", bus.out_valid, 0);
    check("busy_n", bus.busy, 1);
    @(posedge clk);
    #1 check("lat_n1", bus.out_valid, 1);
    wait_idle();
    check("busy_after", bus.busy, 0);
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      strobe(12'(v));
      wait_idle();
    end
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      strobe(12'(v));
      wait_idle();
    end
    strobe(12'h004);
    wait_tap(2'd1);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 check("hold_valid", bus.out_valid, 1);
      check("hold_tap", bus.out_tap, 1);
      check("hold_data", bus.out, sb.size() != 0 ? sb[0].data : 12'hfff);
    end
    bus.out_ready = 1'b1;
    wait_idle();
    do_reset();
    strobe(12'h011);
    @(posedge clk);
    #1 strobe(12'h0AA);
    check("overrun_hi", bus.overrun, 1);
    @(posedge clk);
    #1 check("overrun_lo", bus.overrun, 0);
    wait_idle();
    repeat (4) begin
      @(posedge clk);
      #1 check("no_extra", bus.out_valid, 0);
    end
    strobe(12'h0BB);
    wait_idle();
    do_reset();
    for (int v = 1; v <= 20; v++) begin
      strobe(12'(v));
      wait_idle();
    end
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      strobe(12'(v));
      wait_idle();
    end
    strobe(12'h004);
    wait_tap(2'd2);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    bus.out_ready = 1'b1;
    strobe(12'h007);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/delay_tap_reader.md
Name: delay_tap_reader

Overview:
- Circular sample buffer with a multi-tap read sequencer, for the reverb/echo path.
- The audio-rate strobe writes one sample into the buffer.
- NTAPS delayed samples are then read back and streamed one at a time to the downstream mixer over a valid/ready handshake.
- It is the read-side counterpart of the fixed delay lines: arbitrary per-tap delays, and the consumer may apply backpressure.

Parameters:
- WIDTH, 12: sample width in bits.
- DEPTH, 1024: buffer length in samples. Power of two, at least 4. AW = log2(DEPTH) is a derived localparam.
- NTAPS, 4: taps read per sample strobe. At least 1. TW = max(1, clog2(NTAPS)) is a derived localparam.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- enable, input, 1: sample strobe, one-cycle pulse per audio sample.
- in, input, WIDTH: sample to write, valid when enable=1.
- tap_offset, input, NTAPS*AW: packed delays in samples. Tap k occupies bits [k*AW +: AW].
- out, output, WIDTH: tap sample.
- out_valid, output, 1: out/out_tap/out_last are valid.
- out_ready, input, 1: consumer accepts when out_valid and out_ready are both 1.
- out_tap, output, TW: index of the tap being presented.
- out_last, output, 1: high with tap NTAPS-1.
- busy, output, 1: sequence in progress (state != IDLE).
- overrun, output, 1: one-cycle pulse when a strobe arrives while busy.

Behaviour:
- Reset, checked at every clk edge and overriding everything:
  - wptr=0, fill=0, state=IDLE, tap index=0.
  - out=0, out_valid=0, out_tap=0, out_last=0, busy=0, overrun=0.
  - Buffer contents are not cleared.
- Write side, never stalled:
  - On every enable=1 (including while busy): mem[wptr] <= in, wptr <= wptr+1 mod DEPTH.
  - fill <= min(fill+1, DEPTH).
- Sequence start, on enable=1 in IDLE:
  - Latch base=wptr (the slot being written) and all tap_offset fields.
  - Tap index <= 0; state -> READ.
- READ, one cycle:
  - Issue synchronous read at (base - offset[k]) mod AW bits; state -> PRESENT.
- PRESENT:
  - out_valid=1; out = RAM data, or 0 if offset[k] >= fill (never-written slot).
  - out_tap=k; out_last=(k==NTAPS-1).
  - All outputs are held stable while out_ready=0.
  - On acceptance:
    - If k<NTAPS-1: k <= k+1, out_valid <= 0, state -> READ.
    - Otherwise: state -> IDLE.
- Latency: strobe sampled at edge N gives the first out_valid at edge N+2. Each subsequent tap needs at least 2 cycles.
- Offset 0 returns the sample written by the same strobe. Offset d returns the sample written d strobes earlier.
- Strobe while busy:
  - The sample is still written and fill is updated.
  - No new sequence starts and that strobe's taps are dropped.
  - overrun=1 for exactly one cycle.
  - The current sequence continues against its latched base.
  - A tap with offset DEPTH-1 may then read the newly written sample; this is permitted.
- Strobe in the same cycle as the final acceptance: treated as busy, so it raises overrun.
- Reset mid-sequence: the sequence is abandoned and out_valid=0 after that edge; subsequent reads return 0 until rewritten (fill=0).
- Address arithmetic is unsigned and wraps mod DEPTH. Offsets are AW bits, so no out-of-range check is needed beyond fill.

Test Plan:
(All scenarios use WIDTH=12, DEPTH=16, NTAPS=4, offsets {0,1,3,15}.)
1. Reset, one strobe with in=0x001, out_ready=1 -> taps 0..3 give 0x001, 0, 0, 0 in order; out_tap 0,1,2,3; out_last only on tap 3; first out_valid 2 cycles after strobe; busy low afterward.
2. Strobes of 1..5, each after the prior sequence completes -> the 5th sequence gives 5, 4, 2, 0.
3. Backpressure: out_ready=0 for 3 cycles while tap 1 is presented -> out/out_tap held stable; no tap skipped or duplicated; order resumes 2, 3.
4. Overrun: strobe of 0x0AA mid-sequence -> overrun pulses 1 cycle; no extra sequence; next strobe 0x0BB yields tap0=0x0BB, tap1=0x0AA.
5. Wrap: 20 strobes of values 1..20 -> final sequence gives 20, 19, 17, 5 (offset 15 crosses the wrap).
6. Reset asserted while tap 2 is presented -> out_valid=0 and busy=0 after that edge; next strobe 0x007 yields 0x007, 0, 0, 0.
